// File: rtl/ff_bus_pkg.sv
// ff_bus_pkg: shared state types and constants for the Food Fight NVRAM bus slave
package ff_bus_pkg;
    typedef enum logic [1:0] {IDLE, WAIT, ACK, REL} bus_st_t;
    typedef enum logic {C_IDLE, C_RUN} cp_st_t;
    localparam logic [22:0] NVRAM_BASE = 23'h400000;
    localparam logic [11:0] DT_PAD = 12'hFFF;
endpackage

// File: rtl/dpram_nib.sv
// dpram_nib: 256x4 true dual-port RAM with synchronous read; only the read registers reset
module dpram_nib (
    input  logic       clk,
    input  logic       rst,
    input  logic [7:0] addr_a,
    input  logic       we_a,
    input  logic [3:0] din_a,
    output logic [3:0] q_a,
    input  logic [7:0] addr_b,
    input  logic       we_b,
    input  logic [3:0] din_b,
    output logic [3:0] q_b
);
    logic [3:0] mem [256];
    always_ff @(posedge clk) begin
        if (we_a) mem[addr_a] <= din_a;
        if (we_b) mem[addr_b] <= din_b;
        q_a <= rst ? 4'h0 : mem[addr_a];
        q_b <= rst ? 4'h0 : mem[addr_b];
    end
endmodule

// File: rtl/ff_nvram_slave.sv
// ff_nvram_slave: 68K bus responder for the X2212-style NVRAM with STORE/RECALL copies and a host port
module ff_nvram_slave
    import ff_bus_pkg::*;
#(
    parameter logic [22:0] BASE  = NVRAM_BASE,
    parameter int          WAITS = 2
) (
    input  logic        MCLK,
    input  logic        RESET,
    input  logic [22:0] AD,
    input  logic        AS,
    input  logic        RW,
    input  logic        UDS,
    input  logic        LDS,
    input  logic [15:0] OD,
    output logic        DV,
    output logic        DTACK,
    output logic [15:0] DT,
    input  logic        STORE,
    input  logic        RECALL,
    output logic        BUSY,
    input  logic [7:0]  HST_AD,
    input  logic        HST_WE,
    input  logic [3:0]  HST_DI,
    output logic [3:0]  HST_DO
);
    localparam logic [3:0] WLAST = 4'(WAITS - 1);
    if (WAITS < 1 || WAITS > 15) begin : g_bad_waits
        $error("ff_nvram_slave: WAITS must be in 1..15");
    end
    bus_st_t    st;
    cp_st_t     cst;
    logic [3:0] wcnt;
    logic [8:0] ccnt;
    logic       sto_d, rec_d, pend, pend_rec, cp_rec;
    logic [3:0] ram_qa, ram_qb, sh_qb;
    logic       hit, sto_rise, rec_rise, req, req_rec, start, wr_go, cp_wr;
    logic [7:0] cp_wa;
    logic       unused;
    assign unused   = ^{UDS, OD[15:4]};
    assign hit      = AS && AD[22:8] == BASE[22:8];
    assign DV       = hit && !RESET;
    assign sto_rise = STORE && !sto_d;
    assign rec_rise = RECALL && !rec_d;
    assign req      = sto_rise || rec_rise || pend;
    assign req_rec  = rec_rise || (pend && pend_rec);
    assign start    = cst == C_IDLE && st == IDLE && req;
    assign wr_go    = st == WAIT && AS && wcnt == WLAST;
    // copy writes trail reads by one cycle because of the synchronous read port
    assign cp_wr    = cst == C_RUN && ccnt != 9'd0 && !RESET;
    assign cp_wa    = ccnt[7:0] - 8'd1;
    dpram_nib u_ram (
        .clk(MCLK), .rst(RESET),
        .addr_a(AD[7:0]), .we_a(wr_go && !RW && LDS && !RESET), .din_a(OD[3:0]), .q_a(ram_qa),
        .addr_b(cp_rec ? cp_wa : ccnt[7:0]), .we_b(cp_wr && cp_rec), .din_b(sh_qb), .q_b(ram_qb)
    );
    dpram_nib u_shadow (
        .clk(MCLK), .rst(RESET),
        .addr_a(HST_AD), .we_a(HST_WE && !(BUSY && !cp_rec)), .din_a(HST_DI), .q_a(HST_DO),
        .addr_b(cp_rec ? ccnt[7:0] : cp_wa), .we_b(cp_wr && !cp_rec), .din_b(ram_qb), .q_b(sh_qb)
    );
    always_ff @(posedge MCLK) begin
        if (RESET) begin
            st       <= IDLE;
            cst      <= C_IDLE;
            wcnt     <= 4'd0;
            ccnt     <= 9'd0;
            sto_d    <= 1'b0;
            rec_d    <= 1'b0;
            pend     <= 1'b0;
            pend_rec <= 1'b0;
            cp_rec   <= 1'b0;
            DTACK    <= 1'b0;
            DT       <= 16'h0000;
            BUSY     <= 1'b0;
        end else begin
            sto_d <= STORE;
            rec_d <= RECALL;
            case (st)
                IDLE: if (hit && !BUSY && !start) begin
                    st   <= WAIT;
                    wcnt <= 4'd0;
                end
                WAIT: if (!AS) st <= IDLE;
                else if (wcnt == WLAST) begin
                    st    <= ACK;
                    DTACK <= 1'b1;
                    if (RW) DT <= {DT_PAD, ram_qa};
                end else wcnt <= wcnt + 4'd1;
                ACK: if (!AS) begin
                    st    <= REL;
                    DTACK <= 1'b0;
                end
                default: st <= IDLE;
            endcase
            // edges seen while a copy runs are dropped; otherwise they wait for the bus to go idle
            if (cst == C_IDLE) begin
                if (start) begin
                    cst    <= C_RUN;
                    BUSY   <= 1'b1;
                    ccnt   <= 9'd0;
                    cp_rec <= req_rec;
                    pend   <= 1'b0;
                end else if (req) begin
                    pend     <= 1'b1;
                    pend_rec <= req_rec;
                end
            end else if (ccnt == 9'd256) begin
                cst  <= C_IDLE;
                BUSY <= 1'b0;
            end else ccnt <= ccnt + 9'd1;
        end
    end
endmodule

// File: tb/tb_ff_nvram_slave.sv
// tb_ff_nvram_slave: randomized bench for ff_nvram_slave against array models of RAM and shadow
module tb_ff_nvram_slave;
    logic        MCLK = 0, RESET = 1, AS = 0, RW = 1, UDS = 0, LDS = 0;
    logic        STORE = 0, RECALL = 0, HST_WE = 0;
    logic [22:0] AD = '0;
    logic [15:0] OD = '0;
    logic [7:0]  HST_AD = '0;
    logic [3:0]  HST_DI = '0;
    logic        DV, DTACK, BUSY;
    logic [15:0] DT;
    logic [3:0]  HST_DO;
    logic [3:0]  ram_m [256];
    logic [3:0]  sh_m [256];
    int          total = 0, bad = 0;
    logic        ack_busy;

    ff_nvram_slave dut (
        .MCLK(MCLK), .RESET(RESET), .AD(AD), .AS(AS), .RW(RW), .UDS(UDS), .LDS(LDS), .OD(OD),
        .DV(DV), .DTACK(DTACK), .DT(DT), .STORE(STORE), .RECALL(RECALL), .BUSY(BUSY),
        .HST_AD(HST_AD), .HST_WE(HST_WE), .HST_DI(HST_DI), .HST_DO(HST_DO)
    );

    always #5 MCLK = ~MCLK;

    initial begin
        #1_000_000;
        $display("FAIL timeout: run did not finish");
        $fatal(1, "timeout");
    end

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        total++;
        if (got !== exp) begin
            bad++;
            $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
        end
    endtask

    task automatic tick();
        @(posedge MCLK);
        @(negedge MCLK);
    endtask

    function automatic logic [22:0] adr(input int i);
        return 23'h400000 + 23'(i);
    endfunction

    task automatic cpu(input logic [22:0] a, input logic rw, input logic uds, input logic lds,
                       input logic [15:0] d, input int sto_at, output int lat, output logic [15:0] rd);
        lat = 0;
        AD = a; RW = rw; UDS = uds; LDS = lds; OD = d; AS = 1;
        #1 check("dv_hit", DV, 1);
        while (!DTACK && lat < 600) begin
            if (lat == sto_at) STORE = 1;
            tick();
            lat++;
            if (DTACK && BUSY) ack_busy = 1;
        end
        rd = DT;
        AS = 0; UDS = 0; LDS = 0; STORE = 0;
        tick();
        tick();
    endtask

    task automatic host_wr(input int a, input logic [3:0] d);
        HST_AD = 8'(a); HST_DI = d; HST_WE = 1;
        tick();
        HST_WE = 0;
    endtask

    task automatic host_rd(input int a, output logic [3:0] d);
        HST_AD = 8'(a);
        tick();
        d = HST_DO;
    endtask

    task automatic wait_busy(output logic seen);
        seen = 0;
        for (int k = 0; k < 10 && !seen; k++) begin
            tick();
            seen = BUSY;
        end
    endtask

    task automatic wait_copy(input logic hw, output int len);
        len = 1;
        while (BUSY && len < 400) begin
            HST_AD = 8'h00; HST_DI = ~ram_m[0]; HST_WE = hw && len == 60;
            tick();
            HST_WE = 0;
            if (BUSY) len++;
        end
    endtask

    task automatic rd_chk(input string tag, input int i, input logic [3:0] e);
        int lat; logic [15:0] rd;
        cpu(adr(i), 1, 1, 1, 16'h0, -1, lat, rd);
        check(tag, rd, {12'hFFF, e});
        check({tag, "_lat"}, lat, 3);
    endtask

    initial begin
        int lat, len, idx;
        logic [15:0] rd, d;
        logic [3:0] h, old;
        logic f, u, l;
        logic [22:0] miss [3];
        miss = '{23'h3FFFFF, 23'h400100, 23'h000010};

        AD = 23'h400010; AS = 1; RW = 1;
        repeat (2) tick();
        check("rst_dv", DV, 0);
        check("rst_dtack", DTACK, 0);
        check("rst_dt", DT, 16'h0000);
        check("rst_busy", BUSY, 0);
        check("rst_hst_do", HST_DO, 0);
        AS = 0; RESET = 0;
        tick();

        for (int i = 0; i < 256; i++) begin
            h = 4'($urandom);
            cpu(adr(i), 0, 0, 1, {12'($urandom), h}, -1, lat, rd);
            ram_m[i] = h;
        end
        for (int i = 0; i < 256; i++) begin
            h = 4'($urandom);
            host_wr(i, h);
            sh_m[i] = h;
        end

        cpu(23'h400010, 0, 0, 1, 16'h000A, -1, lat, rd);
        ram_m[16] = 4'hA;
        check("wr_lat", lat, 3);
        rd_chk("rd_10", 16, 4'hA);

        for (int k = 0; k < 16; k++) begin
            idx = $urandom_range(0, 255);
            rd_chk("rand_rd", idx, ram_m[idx]);
        end
        for (int k = 0; k < 16; k++) begin
            idx = $urandom_range(0, 255);
            u = 1'($urandom); l = 1'($urandom); d = 16'($urandom);
            cpu(adr(idx), 0, u, l, d, -1, lat, rd);
            check("rand_wr_lat", lat, 3);
            if (l) ram_m[idx] = d[3:0];
            rd_chk("rand_wr_rb", idx, ram_m[idx]);
        end

        for (int k = 0; k < 3; k++) begin
            AD = miss[k]; RW = 1; AS = 1;
            #1 check("miss_dv", DV, 0);
            f = 0;
            repeat (6) begin tick(); f |= DTACK; end
            AS = 0;
            check("miss_dtack", f, 0);
            tick();
        end

        cpu(23'h400010, 0, 1, 0, 16'h0500, -1, lat, rd);
        check("uds_lat", lat, 3);
        rd_chk("uds_only", 16, 4'hA);

        old = ram_m[48];
        AD = adr(48); RW = 0; LDS = 1; OD = {12'h0, ~old}; AS = 1;
        tick();
        AS = 0; LDS = 0;
        f = 0;
        repeat (4) begin tick(); f |= DTACK; end
        check("abort_dtack", f, 0);
        rd_chk("abort_rb", 48, old);

        STORE = 1;
        tick();
        STORE = 0;
        check("store_busy", BUSY, 1);
        wait_copy(1, len);
        check("store_len", len, 257);
        for (int i = 0; i < 256; i++) sh_m[i] = ram_m[i];
        host_rd(16, h);
        check("hst_10", h, 4'hA);
        for (int i = 0; i < 256; i++) begin
            host_rd(i, h);
            check("store_sh", h, sh_m[i]);
        end

        host_wr(32, 4'h3);
        sh_m[32] = 4'h3;
        for (int k = 0; k < 8; k++) begin
            idx = $urandom_range(33, 255);
            h = 4'($urandom);
            host_wr(idx, h);
            sh_m[idx] = h;
        end
        RECALL = 1;
        tick();
        RECALL = 0;
        ack_busy = 0;
        cpu(23'h400020, 1, 1, 1, 16'h0, -1, lat, rd);
        check("recall_ack_busy", ack_busy, 0);
        check("recall_lat", lat, 260);
        check("recall_20", rd, 16'hFFF3);
        for (int i = 0; i < 256; i++) ram_m[i] = sh_m[i];
        for (int k = 0; k < 8; k++) begin
            idx = $urandom_range(0, 255);
            rd_chk("recall_rd", idx, ram_m[idx]);
        end

        for (int k = 0; k < 4; k++) begin
            idx = $urandom_range(0, 255);
            h = ~ram_m[idx];
            cpu(adr(idx), 0, 0, 1, {12'h0, h}, -1, lat, rd);
            ram_m[idx] = h;
        end
        idx = $urandom_range(0, 255);
        cpu(adr(idx), 1, 1, 1, 16'h0, 1, lat, rd);
        check("pend_rd", rd, {12'hFFF, ram_m[idx]});
        wait_busy(f);
        check("pend_start", f, 1);
        wait_copy(0, len);
        check("pend_len", len, 257);
        for (int i = 0; i < 256; i++) sh_m[i] = ram_m[i];
        for (int k = 0; k < 8; k++) begin
            idx = $urandom_range(0, 255);
            host_rd(idx, h);
            check("pend_sh", h, sh_m[idx]);
        end

        for (int i = 0; i < 256; i++) begin
            host_wr(i, ram_m[i] ^ 4'h5);
            sh_m[i] = ram_m[i] ^ 4'h5;
        end
        STORE = 1; RECALL = 1;
        tick();
        STORE = 0; RECALL = 0;
        wait_copy(0, len);
        check("both_len", len, 257);
        for (int i = 0; i < 256; i++) ram_m[i] = sh_m[i];
        for (int k = 0; k < 8; k++) begin
            idx = $urandom_range(0, 255);
            rd_chk("both_ram", idx, ram_m[idx]);
        end

        for (int i = 0; i < 256; i++) begin
            host_wr(i, ram_m[i] ^ 4'hA);
            sh_m[i] = ram_m[i] ^ 4'hA;
        end
        old = ram_m[200];
        RECALL = 1;
        tick();
        RECALL = 0;
        check("rcl_busy", BUSY, 1);
        repeat (100) tick();
        RESET = 1;
        tick();
        check("rcl_rst_busy", BUSY, 0);
        check("rcl_rst_dtack", DTACK, 0);
        RESET = 0;
        tick();
        for (int i = 0; i < 99; i++) begin
            rd_chk("rcl_part", i, sh_m[i]);
            ram_m[i] = sh_m[i];
        end
        rd_chk("rcl_200", 200, old);

        old = ram_m[64];
        AD = adr(64); RW = 0; LDS = 1; OD = {12'h0, ~old}; AS = 1;
        tick();
        tick();
        RESET = 1;
        tick();
        check("busrst_dtack", DTACK, 0);
        RESET = 0; AS = 0; LDS = 0;
        tick();
        rd_chk("busrst_rb", 64, old);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end
endmodule
